// File: rtl/rs232_tx.sv
// Buffered 8N1 serial transmitter: a byte FIFO feeding a start/data/stop
// serialiser, LSB first, at a fixed number of clocks per bit.
module rs232_tx #(
  parameter int unsigned BAUD_DIV  = 434,
  parameter int unsigned FIFO_LOG2 = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 writeTX,
  input  logic [7:0]           TXchar,
  output logic                 TXempty,
  output logic                 TXidle,
  output logic [FIFO_LOG2:0]   level,
  output logic                 overflow,
  output logic                 TxD
);

  localparam int unsigned DEPTH = 1 << FIFO_LOG2;
  localparam int unsigned PTR_W = FIFO_LOG2;
  localparam int unsigned LVL_W = FIFO_LOG2 + 1;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(BAUD_DIV - 1);
  localparam logic [LVL_W-1:0] LEVEL_FULL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             tx_n;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic             push, pop, fifo_nonempty, baud_tick;

  // Room is judged on the pre-edge count, so a full FIFO refuses even when a pop coincides.
  assign TXempty       = (level != LEVEL_FULL);
  assign fifo_nonempty = (level != '0);
  assign push          = writeTX & TXempty;
  assign TXidle        = ~fifo_nonempty & (state == IDLE);
  assign baud_tick     = (cnt == '0);

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      overflow <= overflow | (writeTX & ~TXempty);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= TXchar;
  end

  // Serialiser state register; TxD is registered from the next-state values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      TxD     <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      TxD     <= tx_n;
    end
  end

  // Next-state, baud counting and FIFO pop (the load event).
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;
    tx_n      = 1'b1;

    if (state != IDLE) cnt_n = baud_tick ? CNT_LOAD : cnt - CNT_W'(1);

    case (state)
      IDLE: begin
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_n = mem[rptr];
          state_n = START;
          cnt_n   = CNT_LOAD;
        end
      end
      START: begin
        if (baud_tick) begin
          state_n   = DATA;
          bit_idx_n = '0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end
      end
      STOP: begin
        // Chain straight into the next start bit when a byte is waiting.
        if (baud_tick) begin
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_n = mem[rptr];
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_rs232_tx.sv
// Scoreboard bench for rs232_tx: a timing model predicts when each accepted
// byte leaves the FIFO; a line receiver decodes frames and checks them.
module tb_rs232_tx;

  localparam int B     = 4;
  localparam int LOG2  = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * B;

  logic        clock = 1'b0;
  logic        reset;
  logic        writeTX;
  logic [7:0]  TXchar;
  logic        TXempty, TXidle, overflow, TxD;
  logic [LOG2:0] level;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  rs232_tx #(.BAUD_DIV(B), .FIFO_LOG2(LOG2)) dut (
    .clock(clock), .reset(reset), .writeTX(writeTX), .TXchar(TXchar),
    .TXempty(TXempty), .TXidle(TXidle), .level(level),
    .overflow(overflow), .TxD(TxD)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [7:0] data; int load; } exp_t;
  exp_t exp_q[$];
  int   load_q[$];
  int   flush_idx = 0;
  int   last_load = -100000;
  int   m_level   = 0;
  bit   m_idle    = 1'b1;
  bit   m_ovf     = 1'b0;
  int   e_m, ld_m;

  // Each accepted byte starts its frame at the later of "next edge" and
  // "previous frame start + one frame"; it occupies the FIFO until then.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      load_q.delete();
      flush_idx = exp_q.size();
      last_load = -100000;
      m_level   = 0;
      m_idle    = 1'b1;
      m_ovf     = 1'b0;
    end else begin
      e_m = cyc + 1;
      while (load_q.size() > 0 && load_q[0] < e_m) void'(load_q.pop_front());
      if (writeTX) begin
        if (load_q.size() < DEPTH) begin
          ld_m = (e_m + 1 > last_load + FRAME) ? e_m + 1 : last_load + FRAME;
          load_q.push_back(ld_m);
          exp_q.push_back('{TXchar, ld_m});
          last_load = ld_m;
        end else begin
          m_ovf = 1'b1;
        end
      end
      while (load_q.size() > 0 && load_q[0] <= e_m) void'(load_q.pop_front());
      m_level = load_q.size();
      m_idle  = (load_q.size() == 0) && (e_m >= last_load + FRAME);
    end
  end

  // ---------------- monitor / line receiver ----------------
  int               rd_idx = 0;
  int               pos    = 0;
  bit               in_frame = 1'b0;
  bit               have_exp = 1'b0;
  exp_t             cur;
  logic [FRAME-1:0] samples;
  logic [9:0]       bits;
  bit               shape_ok;
  int               st_act, st_exp;

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        rd_idx   = flush_idx;
        in_frame = 1'b0;
      end else begin
        st_act = int'({level, TXempty, TXidle, overflow});
        st_exp = m_level * 8 + ((m_level < DEPTH) ? 4 : 0) + (m_idle ? 2 : 0) + (m_ovf ? 1 : 0);
        check("status{level,empty,idle,ovf}", st_act, st_exp);
        if (in_frame) begin
          samples[pos] = TxD;
          pos++;
          if (pos == FRAME) begin
            in_frame = 1'b0;
            shape_ok = 1'b1;
            for (int b = 0; b < 10; b++) begin
              bits[b] = samples[b*B];
              for (int j = 1; j < B; j++)
                if (samples[b*B+j] !== bits[b]) shape_ok = 1'b0;
            end
            check("frame_shape", int'({shape_ok, bits[0], bits[9]}), 5);
            if (have_exp) check("rx_byte", int'(bits[8:1]), int'(cur.data));
          end
        end else if (TxD === 1'b0) begin
          if (rd_idx < exp_q.size()) begin
            cur      = exp_q[rd_idx];
            rd_idx++;
            have_exp = 1'b1;
            check("start_time", cyc, cur.load);
          end else begin
            have_exp = 1'b0;
            tests++;
            fails++;
            $display("FAIL spurious_frame: start bit at cycle %0d, expected no queued byte", cyc);
          end
          samples[0] = TxD;
          pos        = 1;
          in_frame   = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input logic [7:0] b);
    writeTX = 1'b1;
    TXchar  = b;
    @(negedge clock);
    writeTX = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (!TXidle && n < limit) begin
      @(negedge clock);
      n++;
    end
    check("wait_idle_bound", int'(TXidle), 1);
  endtask

  int w;

  initial begin
    reset   = 1'b1;
    writeTX = 1'b0;
    TXchar  = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_txd", int'(TxD), 1);
    check("rst_empty", int'(TXempty), 1);
    check("rst_idle", int'(TXidle), 1);
    check("rst_level", int'(level), 0);
    check("rst_ovf", int'(overflow), 0);
    reset = 1'b0;
    @(negedge clock);

    // single byte
    w = cyc + 1;
    wr(8'h55);
    check("single_level1", int'(level), 1);
    check("single_idle_fall", int'(TXidle), 0);
    @(negedge clock);
    check("single_start_low", int'(TxD), 0);
    check("single_level0", int'(level), 0);
    wait_cyc(w + 40);
    check("single_idle_at40", int'(TXidle), 0);
    @(negedge clock);
    check("single_idle_at41", int'(TXidle), 1);

    // back-to-back
    wr(8'h00); wr(8'hFF); wr(8'hA5);
    wait_idle(400);

    // simultaneous push and pop on the STOP->START load
    w = cyc + 1;
    wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
    check("pp_level_before", int'(level), 3);
    wait_cyc(w + FRAME);
    wr(8'h55);
    check("pp_level_after", int'(level), 3);
    wait_idle(400);

    // fill and overflow
    for (int i = 1; i <= 18; i++) begin
      wr(8'(i));
      if (i == 17) begin
        check("fill_level16", int'(level), 16);
        check("fill_empty0", int'(TXempty), 0);
        check("fill_ovf_before", int'(overflow), 0);
      end
    end
    check("fill_ovf_after", int'(overflow), 1);
    check("fill_level_kept", int'(level), 16);
    wait_idle(1000);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) wr(8'($urandom));
      else @(negedge clock);
    end
    wait_idle(1000);

    // reset during data bit 3 with five bytes queued
    w = cyc + 1;
    for (int i = 0; i < 6; i++) wr(8'hA0 + 8'(i));
    wait_cyc(w + 1 + 17);
    check("mid_level5", int'(level), 5);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_txd", int'(TxD), 1);
    check("mid_rst_level", int'(level), 0);
    check("mid_rst_idle", int'(TXidle), 1);
    check("mid_rst_empty", int'(TXempty), 1);
    check("mid_rst_ovf", int'(overflow), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (100) @(negedge clock);
    check("quiet_txd", int'(TxD), 1);
    check("quiet_idle", int'(TXidle), 1);

    wr(8'hC3);
    wait_idle(100);
    @(negedge clock);
    check("drain_pending", exp_q.size() - rd_idx, 0);
    check("drain_in_frame", int'(in_frame), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
